// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of NUM_SRC lookahead FIFOs into one registered valid/ready stream,
// with a burst limit on consecutive grants to the same source.
module fifo_rr_drain_arbiter #(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 4,
    localparam int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
    output logic [NUM_SRC-1:0]            src_rd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_data/out_src stay frozen while out_valid=1 and out_ready=0.

    logic [NUM_SRC-1:0] req;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   rot_sel;
    logic [SRC_W-1:0]   scan_idx;
    logic [SRC_W-1:0]   sel;
    logic [BURST_W-1:0] burst_cnt;
    logic               rot_found;
    logic               hold;
    logic               load;
    logic               pop;

    assign req  = src_en & ~src_empty;
    assign load = ~out_valid | out_ready;

    // burst_cnt==0 only after reset: nothing has been granted yet, so start with a rotate
    // scan (which begins at source 0) instead of holding the reset value of last_grant.
    assign hold = req[last_grant] && (burst_cnt != '0) && (burst_cnt < BURST_W'(MAX_BURST));

    // Scan runs backwards so the surviving assignment is the first requester after last_grant.
    always_comb begin
        rot_sel   = last_grant;
        rot_found = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            scan_idx = SRC_W'((int'(last_grant) + k) % NUM_SRC);
            if (req[scan_idx]) begin
                rot_sel   = scan_idx;
                rot_found = 1'b1;
            end
        end
    end

    assign sel = hold ? last_grant : rot_sel;
    assign pop = load & (hold | rot_found) & ~rst;

    always_comb begin
        src_rd = '0;
        if (pop) begin
            src_rd[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
            burst_cnt  <= '0;
        end else if (load) begin
            if (pop) begin
                out_valid  <= 1'b1;
                out_data   <= src_dout[sel*DATA_WIDTH +: DATA_WIDTH];
                out_src    <= sel;
                last_grant <= sel;
                burst_cnt  <= hold ? burst_cnt + BURST_W'(1) : BURST_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed bench for fifo_rr_drain_arbiter: queue-modelled lookahead FIFOs, per-source
// scoreboard on accepted words, hand-computed grant/data sequences.
module tb_fifo_rr_drain_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    src_en;
    logic [NS-1:0]    src_empty;
    logic [NS*DW-1:0] src_dout;
    logic [NS-1:0]    src_rd;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;

    fifo_rr_drain_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_en    (src_en),
        .src_empty (src_empty),
        .src_dout  (src_dout),
        .src_rd    (src_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // FIFO model and scoreboard
    logic [DW-1:0]   fq[NS][$];
    logic [DW-1:0]   exp_q[NS][$];
    logic [DW+1:0]   acc_q[$];
    logic [NS-1:0]   last_rd;
    logic            pre_stall;
    logic [DW-1:0]   pre_data;
    logic [1:0]      pre_src;
    int              errors = 0;
    int              checks = 0;

    logic [3:0]  t1_rd[5]  = '{4'd4, 4'd4, 4'd4, 4'd0, 4'd0};
    logic        t1_v[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] t1_d[3]   = '{32'h5A, 32'hF6, 32'h09};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic apply_fifos();
        for (int i = 0; i < NS; i++) begin
            src_empty[i]        = (fq[i].size() == 0);
            src_dout[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    // One clock: drive FIFO heads, sample away from the edge, pop on the edge,
    // and land on the next falling edge with registered outputs settled.
    task automatic tick();
        logic [DW-1:0] w;
        apply_fifos();
        #1;
        last_rd   = src_rd;
        pre_stall = out_valid && !out_ready && !rst;
        pre_data  = out_data;
        pre_src   = out_src;
        if (out_valid && out_ready && !rst) begin
            acc_q.push_back({out_src, out_data});
            if (exp_q[out_src].size() != 0) w = exp_q[out_src].pop_front();
            else w = 'x;
            chk("word", out_data, w);
        end
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            if (last_rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        @(negedge clk);
        if (pre_stall) begin
            chk("stall_rd", last_rd, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pre_data);
            chk("stall_src", out_src, pre_src);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < NS; s++) exp_q[s] = fq[s];
        acc_q.delete();
    endtask

    task automatic flush();
        for (int s = 0; s < NS; s++) begin
            fq[s].delete();
            exp_q[s].delete();
        end
        acc_q.delete();
    endtask

    task automatic load(input int s, input logic [DW-1:0] w);
        fq[s].push_back(w);
        exp_q[s].push_back(w);
    endtask

    // directed tests
    initial begin
        int pops;
        int cyc;
        bit done;
        int exp_src;
        int j;

        rst       = 1'b1;
        src_en    = '1;
        out_ready = 1'b1;
        src_empty = '1;
        src_dout  = '0;

        do_reset();
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_src", out_src, 0);
        chk("reset_rd", last_rd, 0);
        chk("reset_burst", dut.burst_cnt, 0);

        // single source 2, three words
        flush();
        load(2, 32'h5A);
        load(2, 32'hF6);
        load(2, 32'h09);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t1_rd", last_rd, t1_rd[c]);
            chk("t1_valid", out_valid, t1_v[c]);
            if (c < 3) begin
                chk("t1_data", out_data, t1_d[c]);
                chk("t1_src", out_src, 2);
            end
        end

        // all four sources, 8 words each: bursts of 4 in rotation
        flush();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 8; k++) load(s, {16'hA000, 8'(s), 8'(k)});
        do_reset();
        pops = 0;
        for (int c = 0; c < 33; c++) begin
            tick();
            if (c < 32 && last_rd != '0) pops++;
        end
        chk("t2_pops", pops, 32);
        chk("t2_count", acc_q.size(), 32);
        for (int k = 0; k < 32 && k < acc_q.size(); k++) begin
            exp_src = (k / 4) % 4;
            j = (k / 16) * 4 + k % 4;
            chk("t2_src", acc_q[k][DW+1:DW], exp_src);
            chk("t2_data", acc_q[k][DW-1:0], {16'hA000, 8'(exp_src), 8'(j)});
        end

        // random backpressure on sources 0 and 1
        flush();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 6; k++) load(s, {16'hB000, 8'(s), 8'(k)});
        do_reset();
        done = 0;
        cyc = 0;
        while (!done && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (fq[0].size() == 0 && fq[1].size() == 0 && !out_valid) done = 1;
        end
        out_ready = 1'b1;
        chk("t3_drained", done, 1);
        chk("t3_count", acc_q.size(), 12);
        chk("t3_sb0_left", exp_q[0].size(), 0);
        chk("t3_sb1_left", exp_q[1].size(), 0);

        // lone source 3 with 10 words: burst expiry without a bubble
        flush();
        for (int k = 0; k < 10; k++) load(3, {16'hD000, 8'd3, 8'(k)});
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t4_rd", last_rd, 4'b1000);
            chk("t4_burst", dut.burst_cnt, (c % 4) + 1);
        end
        tick();
        chk("t4_rd_end", last_rd, 0);
        chk("t4_valid_end", out_valid, 0);
        chk("t4_count", acc_q.size(), 10);

        // enable mask: only source 1 eligible, then disabled mid-burst
        flush();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 8; k++) load(s, {16'hE000, 8'(s), 8'(k)});
        src_en = 4'b1110;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_rd", last_rd, 4'b0010);
            chk("t5_src", out_src, 1);
            chk("t5_data", out_data, {16'hE000, 8'd1, 8'(c)});
        end
        chk("t5_valid", out_valid, 1);
        src_en = 4'b1100;
        tick();
        chk("t5_rd_off", last_rd, 0);
        chk("t5_valid_off", out_valid, 0);
        src_en = '1;

        // reset mid-stream discards the pending word
        flush();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 4; k++) load(s, {16'hC000, 8'(s), 8'(k)});
        do_reset();
        tick();
        tick();
        chk("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_rd", last_rd, 0);
        chk("t6_rst_valid", out_valid, 0);
        rst = 1'b0;
        for (int s = 0; s < NS; s++) exp_q[s] = fq[s];
        tick();
        chk("t6_first_rd", last_rd, 4'b0001);
        chk("t6_first_data", out_data, {16'hC000, 8'd0, 8'd2});
        for (int c = 0; c < 10; c++) tick();
        chk("t6_sb0_left", exp_q[0].size(), 0);
        chk("t6_sb1_left", exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
